// File: rtl/datapath_pkg.sv
// Datapath types shared between fetch, scoreboard and execute.
package datapath_pkg;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_t;

   typedef enum logic [1:0] {
      REQ,
      FLUSH_WAIT,
      HALTED
   } fetch_state_t;
endpackage

// File: rtl/isa_pkg.sv
// ISA-level constants shared across the tensor-core control pipeline.
package isa_pkg;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO holding fetched instructions; head is presented combinationally.
module fetch_queue #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_head];
   assign w_pop   = i_pop & ~o_empty;
   // A push into a full queue is only accepted when a pop frees the slot the same cycle.
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_tail] <= i_din;
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request FSM, redirect/squash and halt handling.
module fetch_unit
   import datapath_pkg::*;
   import isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_ren,
   output logic [31:0] imem_addr,
   input  logic        imem_ihit,
   input  logic [31:0] imem_rdata,
   output fetch_t      fetch,
   output logic        fetch_valid,
   input  logic        sb_ready,
   input  logic        branch_miss,
   input  logic [31:0] branch_target,
   output logic        halted
);
   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_stale_addr, w_stale_nxt;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_ren;
   fetch_t       w_din;
   fetch_t       w_head;

   fetch_queue #(
      .WIDTH ($bits(fetch_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (branch_miss),
      .i_din   (w_din),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_comb begin
      w_ren = 1'b0;
      if (!RST) begin
         case (r_state)
            REQ:        w_ren = ~w_full;
            FLUSH_WAIT: w_ren = 1'b1;
            default:    w_ren = 1'b0;
         endcase
      end
   end

   assign imem_ren    = w_ren;
   // pc_r already holds the redirect target while the stale request is still on the bus.
   assign imem_addr   = RST ? RESET_PC : ((r_state == FLUSH_WAIT) ? r_stale_addr : r_pc);
   assign fetch_valid = ~RST & ~w_empty;
   assign fetch       = w_head;
   assign halted      = ~RST & (r_state == HALTED);
   assign w_pop       = fetch_valid & sb_ready & ~branch_miss;
   assign w_din       = '{instr: imem_rdata, pc: r_pc};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_stale_nxt = r_stale_addr;
      w_push      = 1'b0;
      if (branch_miss) begin
         w_pc_nxt    = branch_target & ~32'h3;
         w_state_nxt = (w_ren & ~imem_ihit) ? FLUSH_WAIT : REQ;
         if (r_state != FLUSH_WAIT) w_stale_nxt = r_pc;
      end else begin
         case (r_state)
            REQ: begin
               if (w_ren && imem_ihit) begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + 32'd4;
                  if (imem_rdata == HALT_INSTR) w_state_nxt = HALTED;
               end
            end
            FLUSH_WAIT: begin
               if (imem_ihit) w_state_nxt = REQ;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= REQ;
         r_pc         <= RESET_PC;
         r_stale_addr <= RESET_PC;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_stale_addr <= w_stale_nxt;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table for streaming/stall, hand sequences for redirect, halt, reset.
module tb_fetch_unit;
   import datapath_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        imem_ihit;
   logic [31:0] imem_rdata;
   fetch_t      fetch;
   logic        fetch_valid;
   logic        sb_ready;
   logic        branch_miss;
   logic [31:0] branch_target;
   logic        halted;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .imem_ren      (imem_ren),
      .imem_addr     (imem_addr),
      .imem_ihit     (imem_ihit),
      .imem_rdata    (imem_rdata),
      .fetch         (fetch),
      .fetch_valid   (fetch_valid),
      .sb_ready      (sb_ready),
      .branch_miss   (branch_miss),
      .branch_target (branch_target),
      .halted        (halted)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   fetch_t      sb_q[$];
   fetch_t      pend;
   bit          pend_push = 1'b0;
   bit          halt_en   = 1'b0;
   logic [31:0] halt_addr = 32'h0;

   typedef struct {
      logic        ihit;
      logic        sb;
      logic        acc;
      logic        exp_ren;
      logic [31:0] exp_addr;
   } vec_t;
   vec_t vt[9];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drv(input bit ihit, input bit acc, input bit sb, input logic [31:0] addr);
      imem_ihit  = ihit;
      imem_rdata = ihit ? mem_word(addr) : 32'h0;
      sb_ready   = sb;
      pend_push  = acc;
      pend.pc    = addr;
      pend.instr = mem_word(addr);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      branch_miss   = 1'b1;
      branch_target = tgt;
   endtask

   // Scoreboard update for the coming edge, then post-edge check of queue head.
   task automatic tick();
      fetch_t tmp;
      if (RST || branch_miss) sb_q.delete();
      else begin
         if (sb_ready && sb_q.size() != 0) tmp = sb_q.pop_front();
         if (pend_push) sb_q.push_back(pend);
      end
      pend_push = 1'b0;
      @(posedge CLK);
      #1;
      branch_miss = 1'b0;
      imem_ihit   = 1'b0;
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, sb_q.size() != 0});
      if (sb_q.size() != 0) begin
         chk("fetch.pc", fetch.pc, sb_q[0].pc);
         chk("fetch.instr", fetch.instr, sb_q[0].instr);
      end
   endtask

   initial begin
      //        ihit  sb   acc  ren  addr
      vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00};
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C};
      vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10};
      vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h14};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h14};
      vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h14};
      vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h14};

      RST = 1'b1; imem_ihit = 1'b0; imem_rdata = '0; sb_ready = 1'b1;
      branch_miss = 1'b0; branch_target = '0;
      tick();
      tick();
      chk("rst imem_ren", {31'b0, imem_ren}, 32'd0);
      chk("rst imem_addr", imem_addr, 32'h0);
      chk("rst halted", {31'b0, halted}, 32'd0);
      RST = 1'b0;
      #1;

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("vec%0d imem_ren", i), {31'b0, imem_ren}, {31'b0, vt[i].exp_ren});
         chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].exp_addr);
         drv(vt[i].ihit, vt[i].acc, vt[i].sb, vt[i].exp_addr);
         tick();
      end

      // Redirect while 0x18 is outstanding: stale response dropped, then fetch at 0x100.
      chk("pend imem_addr", imem_addr, 32'h18);
      drv(1'b0, 1'b0, 1'b1, 32'h18);
      redirect(32'h100);
      tick();
      chk("flush imem_ren", {31'b0, imem_ren}, 32'd1);
      chk("flush imem_addr", imem_addr, 32'h18);
      drv(1'b0, 1'b0, 1'b1, 32'h18);
      tick();
      chk("flush hold addr", imem_addr, 32'h18);
      drv(1'b1, 1'b0, 1'b1, 32'h18);
      tick();
      chk("tgt imem_ren", {31'b0, imem_ren}, 32'd1);
      chk("tgt imem_addr", imem_addr, 32'h100);
      drv(1'b1, 1'b1, 1'b0, 32'h100);
      tick();
      chk("seq after tgt", imem_addr, 32'h104);

      // Redirect coinciding with ihit and pop.
      drv(1'b1, 1'b0, 1'b1, 32'h104);
      redirect(32'h200);
      tick();
      chk("bm+hit imem_ren", {31'b0, imem_ren}, 32'd1);
      chk("bm+hit imem_addr", imem_addr, 32'h200);
      drv(1'b0, 1'b0, 1'b1, 32'h200);
      tick();
      drv(1'b1, 1'b1, 1'b0, 32'h200);
      tick();
      chk("after 0x200", imem_addr, 32'h204);

      // Misaligned target is word-aligned.
      drv(1'b1, 1'b0, 1'b1, 32'h204);
      redirect(32'h103);
      tick();
      chk("misalign imem_addr", imem_addr, 32'h100);

      // Halt instruction at 0x8.
      halt_en = 1'b1; halt_addr = 32'h8;
      drv(1'b1, 1'b0, 1'b1, 32'h100);
      redirect(32'h0);
      tick();
      chk("halt seq addr0", imem_addr, 32'h0);
      drv(1'b1, 1'b1, 1'b1, 32'h0);
      tick();
      drv(1'b1, 1'b1, 1'b1, 32'h4);
      tick();
      chk("halt seq addr8", imem_addr, 32'h8);
      drv(1'b1, 1'b1, 1'b1, 32'h8);
      tick();
      chk("halted set", {31'b0, halted}, 32'd1);
      chk("halted ren", {31'b0, imem_ren}, 32'd0);
      drv(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("halted hold", {31'b0, halted}, 32'd1);
      drv(1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("halted drained", {31'b0, halted}, 32'd1);
      chk("halted drained ren", {31'b0, imem_ren}, 32'd0);
      drv(1'b0, 1'b0, 1'b1, 32'h0);
      redirect(32'h4);
      tick();
      chk("resume halted", {31'b0, halted}, 32'd0);
      chk("resume ren", {31'b0, imem_ren}, 32'd1);
      chk("resume addr", imem_addr, 32'h4);
      drv(1'b1, 1'b1, 1'b0, 32'h4);
      tick();
      chk("resume next addr", imem_addr, 32'h8);

      // Reset mid-stream.
      RST = 1'b1;
      drv(1'b0, 1'b0, 1'b0, 32'h8);
      tick();
      chk("midrst imem_ren", {31'b0, imem_ren}, 32'd0);
      chk("midrst imem_addr", imem_addr, 32'h0);
      chk("midrst halted", {31'b0, halted}, 32'd0);
      RST = 1'b0;
      #1;
      chk("post rst ren", {31'b0, imem_ren}, 32'd1);
      chk("post rst addr", imem_addr, 32'h0);
      chk("post rst valid", {31'b0, fetch_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
